// File: rtl/karatsuba_mult_pipe.sv
// Three-stage pipelined Karatsuba multiplier with per-op signed/unsigned mode and a sideband tag.
// Handshake on both sides; the whole pipeline stalls together under output backpressure.
module karatsuba_mult_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_signed,
  input  logic [DATA_WIDTH-1:0]   dat1,
  input  logic [DATA_WIDTH-1:0]   dat2,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic [TAG_WIDTH-1:0]    out_tag
);

  localparam int W = DATA_WIDTH;
  localparam int H = DATA_WIDTH / 2;

  // Magnitude of a two's-complement operand; the most negative value maps to 2^(W-1) as unsigned.
  function automatic logic [W-1:0] abs_mag(input logic [W-1:0] v, input logic is_signed);
    logic signed [W-1:0] sv;
    sv = v;
    if (is_signed && sv < 0) abs_mag = -sv;
    else                     abs_mag = v;
  endfunction

  function automatic logic [2*W-1:0] apply_sign(input logic [2*W-1:0] mag, input logic neg);
    logic signed [2*W-1:0] sm;
    sm = mag;
    apply_sign = neg ? -sm : sm;
  endfunction

  logic adv, take;
  logic [W-1:0] mag1, mag2;
  logic         neg_in;

  logic             vld_p1, vld_p2;
  logic [H-1:0]     a_p1, b_p1, c_p1, d_p1;
  logic [H:0]       sab_p1, scd_p1;
  logic             neg_p1, neg_p2;
  logic [TAG_WIDTH-1:0] tag_p1, tag_p2;
  logic [W-1:0]     p_hi_p2, p_lo_p2;
  logic [W+1:0]     p_mid_p2;
  logic [W:0]       mid_s3;
  logic [2*W:0]     mag_s3;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign take     = in_valid && adv;

  assign mag1   = abs_mag(dat1, in_signed);
  assign mag2   = abs_mag(dat2, in_signed);
  assign neg_in = in_signed && (dat1[W-1] ^ dat2[W-1]);

  // Stage S1 -> S2 -> S3 control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      out_valid <= 1'b0;
      product   <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      vld_p1    <= take;
      vld_p2    <= vld_p1;
      out_valid <= vld_p2;
      if (vld_p2) begin
        product <= apply_sign((2*W)'(mag_s3), neg_p2);
        out_tag <= tag_p2;
      end
    end
  end

  // Stage S1: operand split and pre-add sums (carry kept)
  always_ff @(posedge clk) begin
    if (take) begin
      a_p1   <= mag1[W-1:H];
      b_p1   <= mag1[H-1:0];
      c_p1   <= mag2[W-1:H];
      d_p1   <= mag2[H-1:0];
      sab_p1 <= {1'b0, mag1[W-1:H]} + {1'b0, mag1[H-1:0]};
      scd_p1 <= {1'b0, mag2[W-1:H]} + {1'b0, mag2[H-1:0]};
      neg_p1 <= neg_in;
      tag_p1 <= in_tag;
    end
  end

  // Stage S2: the three half-width products
  always_ff @(posedge clk) begin
    if (adv && vld_p1) begin
      p_hi_p2  <= {{H{1'b0}}, a_p1} * {{H{1'b0}}, c_p1};
      p_lo_p2  <= {{H{1'b0}}, b_p1} * {{H{1'b0}}, d_p1};
      p_mid_p2 <= {{(H+1){1'b0}}, sab_p1} * {{(H+1){1'b0}}, scd_p1};
      neg_p2   <= neg_p1;
      tag_p2   <= tag_p1;
    end
  end

  // Stage S3: recombination; mid = ad + bc is never negative
  assign mid_s3 = (W+1)'(p_mid_p2 - {2'b00, p_hi_p2} - {2'b00, p_lo_p2});
  assign mag_s3 = ({{(W+1){1'b0}}, p_hi_p2} << W)
                + ({{W{1'b0}}, mid_s3} << H)
                + {{(W+1){1'b0}}, p_lo_p2};

endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// Directed and randomized checks of karatsuba_mult_pipe against a wide-integer reference model
// with an in-order scoreboard, output-hold and handshake checks every cycle.
module tb_karatsuba_mult_pipe;

  localparam int W = 32;
  localparam int T = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready, in_signed;
  logic [W-1:0]   dat1, dat2;
  logic [T-1:0]   in_tag;
  logic           out_valid, out_ready;
  logic [2*W-1:0] product;
  logic [T-1:0]   out_tag;

  karatsuba_mult_pipe #(.DATA_WIDTH(W), .TAG_WIDTH(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .dat1(dat1), .dat2(dat2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [T-1:0]   tag;
    logic [2*W-1:0] prod;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  logic           s_irdy, s_ovld;
  logic [2*W-1:0] s_prod;
  logic [T-1:0]   s_otag;
  logic           prev_stall = 1'b0;
  logic [2*W-1:0] prev_prod;
  logic [T-1:0]   prev_tag;
  logic           last_acc;

  function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    logic signed [127:0] xs, ys, pr;
    if (s) begin
      xs = $signed(x);
      ys = $signed(y);
    end else begin
      xs = $signed({{(128-W){1'b0}}, x});
      ys = $signed({{(128-W){1'b0}}, y});
    end
    pr = xs * ys;
    return pr[2*W-1:0];
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      4:       return {{(W-1){1'b0}}, 1'b1};
      default: return W'($urandom);
    endcase
  endfunction

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, got, exp);
    end
  endtask

  // One clock cycle: drive, sample at the falling edge, score, then advance past the rising edge.
  task automatic step(input logic v, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [T-1:0] tg, input logic ordy, input logic [2*W-1:0] e);
    exp_t ex;
    in_valid = v; in_signed = s; dat1 = x; dat2 = y; in_tag = tg; out_ready = ordy;
    @(negedge clk);
    s_irdy = in_ready; s_ovld = out_valid; s_prod = product; s_otag = out_tag;
    check("in_ready", s_irdy, !s_ovld || ordy);
    if (prev_stall) begin
      check("hold_valid", s_ovld, 1'b1);
      check("hold_data", {s_otag, s_prod}, {prev_tag, prev_prod});
    end
    if (s_ovld && ordy) begin
      check("sb_nonempty", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        ex = sb.pop_front();
        check("result", {s_otag, s_prod}, {ex.tag, ex.prod});
      end
    end
    last_acc = v && s_irdy;
    if (last_acc) sb.push_back('{tag: tg, prod: e});
    prev_stall = s_ovld && !ordy;
    prev_prod  = s_prod;
    prev_tag   = s_otag;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, '0, '0, '0, ordy, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1'b1);
    check("drain_empty", sb.size(), 0);
    idle(1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] bx[5], by[5];
  logic         pend, p_s;
  logic [W-1:0] p_x, p_y;
  logic [T-1:0] p_t;
  int           k, n_done;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0; dat1 = '0; dat2 = '0;
    in_tag = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_product", product, 0);
    check("rst_out_tag", out_tag, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1'b1);

    // Latency and full-scale unsigned
    step(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 1'b1, 64'hFFFF_FFFE_0000_0001);
    for (int i = 1; i <= 3; i++) begin
      idle(1'b1);
      check("latency_valid", s_ovld, i == 3);
      if (i == 3) check("latency_data", {s_otag, s_prod}, {4'd5, 64'hFFFF_FFFE_0000_0001});
    end
    drain();

    // Signed corner cases
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 1'b1, 64'h0000_0000_0000_0001);
    step(1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 4'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);
    step(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 4'd3, 1'b1, 64'h4000_0000_0000_0000);
    step(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, 4'd4, 1'b1, 64'hFFFF_FFFF_8000_0000);
    step(1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFB, 4'd6, 1'b1, 64'h0);
    step(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, 1'b1, 64'h7FFF_FFFF_8000_0000);
    drain();

    // Back-to-back, no gaps
    for (int i = 0; i < 11; i++) begin
      p_x = W'($urandom);
      p_y = W'($urandom);
      step(i < 8, 1'b0, p_x, p_y, T'(i), 1'b1, ref_mul(1'b0, p_x, p_y));
      if (i >= 3) begin
        check("b2b_valid", s_ovld, 1'b1);
        check("b2b_tag", s_otag, T'(i - 3));
      end
    end
    drain();

    // Backpressure: only three ops fit while the consumer is stalled
    for (int i = 0; i < 5; i++) begin
      bx[i] = W'($urandom);
      by[i] = W'($urandom);
    end
    k = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, bx[k], by[k], T'(8 + k), 1'b0, ref_mul(1'b1, bx[k], by[k]));
      if (last_acc) k++;
    end
    check("bp_accepted", k, 3);
    check("bp_in_ready", s_irdy, 1'b0);
    for (int i = 0; i < 30 && (k < 5 || sb.size() > 0); i++) begin
      step(k < 5, 1'b1, bx[k % 5], by[k % 5], T'(8 + k), 1'b1,
           ref_mul(1'b1, bx[k % 5], by[k % 5]));
      if (last_acc) k++;
    end
    check("bp_all_accepted", k, 5);
    check("bp_all_emerged", sb.size(), 0);
    drain();

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'(i + 2), W'(9), T'(i), 1'b1, 64'(18 + 9 * i));
    check("inflight_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_product", product, 0);
    sb.delete();
    prev_stall = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      check("post_rst_quiet", s_ovld, 1'b0);
    end
    step(1'b1, 1'b0, W'(7), W'(6), 4'd3, 1'b1, 64'd42);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    check("post_rst_42", {s_ovld, s_otag, s_prod}, {1'b1, 4'd3, 64'd42});
    drain();

    // Randomized traffic with random backpressure; pending ops are held until taken
    pend = 1'b0; n_done = 0;
    p_s = 1'b0; p_x = '0; p_y = '0; p_t = '0;
    for (int i = 0; i < 60000 && n_done < 10000; i++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        p_s  = 1'($urandom);
        p_x  = pick_operand();
        p_y  = pick_operand();
        p_t  = T'($urandom);
      end
      step(pend, p_s, p_x, p_y, p_t, $urandom_range(0, 3) != 0, ref_mul(p_s, p_x, p_y));
      if (last_acc) begin
        pend = 1'b0;
        n_done++;
      end
    end
    check("random_done", n_done, 10000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
